// File: rtl/fifo_wrarb.sv
// Round-robin write-port arbiter: NREQ producers share one fifo write port,
// each grant covering a packet of up to BURST beats.
module fifo_wrarb #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       last_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       ack_o,
  output logic                  write_o,
  output logic [WIDTH-1:0]      data_o,
  input  logic                  full_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [IW-1:0]   gidx_q,  gidx_d;
  logic [IW-1:0]   ptr_q,   ptr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic            found;
  logic [IW-1:0]   sel_idx;
  logic            release_now;
  int              idx;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        sel_idx = IW'(idx);
      end
    end
  end

  assign gnt_o   = gnt_q;
  assign write_o = (state_q == BUSY) && req_i[gidx_q] && !full_i;
  assign ack_o   = gnt_q & {NREQ{write_o}};
  assign data_o  = data_i[gidx_q*WIDTH +: WIDTH];

  // Abandoning the grant (req dropped) releases without a write.
  assign release_now = !req_i[gidx_q] ||
                       (write_o && (last_i[gidx_q] || cnt_q == CW'(BURST-1)));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = BUSY;
          gidx_d  = sel_idx;
          gnt_d   = '0;
          gnt_d[sel_idx] = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (write_o) cnt_d = cnt_q + 1'b1;
        if (release_now) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == IW'(NREQ-1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wrarb.sv
// Directed bench for fifo_wrarb: two instances, BURST=4 for framing tests
// and BURST=2 for fairness.
module tb_fifo_wrarb;

  logic        clk = 1'b0;
  logic        rst_i;

  logic [1:0]  req_a, last_a, gnt_a, ack_a;
  logic [15:0] data_a;
  logic        full_a, write_a;
  logic [7:0]  dout_a;

  logic [1:0]  req_b, last_b, gnt_b, ack_b;
  logic [15:0] data_b;
  logic        full_b, write_b;
  logic [7:0]  dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wrarb #(.NREQ(2), .WIDTH(8), .BURST(4)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_a), .last_i(last_a), .data_i(data_a),
    .gnt_o(gnt_a), .ack_o(ack_a), .write_o(write_a), .data_o(dout_a), .full_i(full_a)
  );

  fifo_wrarb #(.NREQ(2), .WIDTH(8), .BURST(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_b), .last_i(last_b), .data_i(data_b),
    .gnt_o(gnt_b), .ack_o(ack_b), .write_o(write_b), .data_o(dout_b), .full_i(full_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply dut_a inputs at the falling edge, then let combinational outputs settle.
  task automatic step_a(input logic [1:0] req, input logic [1:0] last,
                        input logic [7:0] d0, input logic [7:0] d1, input logic full);
    @(negedge clk);
    req_a  = req;
    last_a = last;
    data_a = {d1, d0};
    full_a = full;
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [1:0] gnt, input logic wr,
                          input logic [1:0] ack, input logic [7:0] dat);
    check({tag, ".gnt"}, 32'(gnt_a), 32'(gnt));
    check({tag, ".write"}, 32'(write_a), 32'(wr));
    check({tag, ".ack"}, 32'(ack_a), 32'(ack));
    if (wr) check({tag, ".data"}, 32'(dout_a), 32'(dat));
  endtask

  logic [1:0] fair_gnt [10];

  initial begin
    rst_i  = 1'b1;
    req_a  = '0; last_a = '0; data_a = '0; full_a = 1'b0;
    req_b  = '0; last_b = '0; data_b = 16'hB2B1; full_b = 1'b0;
    fair_gnt = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};

    // Reset state
    step_a(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    expect_a("reset", 2'b00, 1'b0, 2'b00, 8'h00);
    check("reset.gnt_b", 32'(gnt_b), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;

    // Single source: three beats, last on the third
    step_a(2'b01, 2'b00, 8'h11, 8'h00, 1'b0);
    expect_a("single.req", 2'b00, 1'b0, 2'b00, 8'h00);
    step_a(2'b01, 2'b00, 8'h11, 8'h00, 1'b0);
    expect_a("single.b0", 2'b01, 1'b1, 2'b01, 8'h11);
    step_a(2'b01, 2'b00, 8'h22, 8'h00, 1'b0);
    expect_a("single.b1", 2'b01, 1'b1, 2'b01, 8'h22);
    step_a(2'b01, 2'b01, 8'h33, 8'h00, 1'b0);
    expect_a("single.b2", 2'b01, 1'b1, 2'b01, 8'h33);
    step_a(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    expect_a("single.rel", 2'b00, 1'b0, 2'b00, 8'h00);

    // Backpressure mid-burst; burst of 4 ends on the count, not on last
    step_a(2'b01, 2'b00, 8'hA0, 8'h00, 1'b0);
    expect_a("bp.req", 2'b00, 1'b0, 2'b00, 8'h00);
    step_a(2'b01, 2'b00, 8'hA0, 8'h00, 1'b0);
    expect_a("bp.b0", 2'b01, 1'b1, 2'b01, 8'hA0);
    for (int i = 0; i < 3; i++) begin
      step_a(2'b01, 2'b00, 8'hA1, 8'h00, 1'b1);
      expect_a($sformatf("bp.full%0d", i), 2'b01, 1'b0, 2'b00, 8'h00);
    end
    step_a(2'b01, 2'b00, 8'hA1, 8'h00, 1'b0);
    expect_a("bp.b1", 2'b01, 1'b1, 2'b01, 8'hA1);
    step_a(2'b01, 2'b00, 8'hA2, 8'h00, 1'b0);
    expect_a("bp.b2", 2'b01, 1'b1, 2'b01, 8'hA2);
    step_a(2'b01, 2'b00, 8'hA3, 8'h00, 1'b0);
    expect_a("bp.b3", 2'b01, 1'b1, 2'b01, 8'hA3);
    step_a(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    expect_a("bp.rel", 2'b00, 1'b0, 2'b00, 8'h00);

    // Abandon: req1 drops after one beat while req0 rises; ptr wraps to 0
    step_a(2'b10, 2'b00, 8'h00, 8'hB0, 1'b0);
    expect_a("ab.req", 2'b00, 1'b0, 2'b00, 8'h00);
    step_a(2'b10, 2'b00, 8'h00, 8'hB0, 1'b0);
    expect_a("ab.b0", 2'b10, 1'b1, 2'b10, 8'hB0);
    step_a(2'b01, 2'b00, 8'hC0, 8'hB1, 1'b0);
    expect_a("ab.drop", 2'b10, 1'b0, 2'b00, 8'h00);
    step_a(2'b01, 2'b00, 8'hC0, 8'h00, 1'b0);
    expect_a("ab.idle", 2'b00, 1'b0, 2'b00, 8'h00);
    step_a(2'b01, 2'b01, 8'hC0, 8'h00, 1'b0);
    expect_a("ab.next", 2'b01, 1'b1, 2'b01, 8'hC0);
    step_a(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    expect_a("ab.rel", 2'b00, 1'b0, 2'b00, 8'h00);

    // Reset during the second beat of a req1 burst (ptr is 1 beforehand)
    step_a(2'b10, 2'b00, 8'h00, 8'hD0, 1'b0);
    expect_a("rst.req", 2'b00, 1'b0, 2'b00, 8'h00);
    step_a(2'b10, 2'b00, 8'h00, 8'hD0, 1'b0);
    expect_a("rst.b0", 2'b10, 1'b1, 2'b10, 8'hD0);
    step_a(2'b11, 2'b00, 8'hE0, 8'hD1, 1'b0);
    expect_a("rst.b1", 2'b10, 1'b1, 2'b10, 8'hD1);
    #1 rst_i = 1'b1;
    #1;
    expect_a("rst.async", 2'b00, 1'b0, 2'b00, 8'h00);
    #1 rst_i = 1'b0;
    step_a(2'b00, 2'b00, 8'hE0, 8'h00, 1'b0);
    expect_a("rst.ptr0", 2'b01, 1'b0, 2'b00, 8'h00);
    step_a(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    expect_a("rst.rel", 2'b00, 1'b0, 2'b00, 8'h00);

    // Fairness: both requesters held, BURST=2, no last
    @(negedge clk);
    req_b = 2'b11;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("fair%0d.gnt", i), 32'(gnt_b), 32'(fair_gnt[i]));
      check($sformatf("fair%0d.ack", i), 32'(ack_b), 32'(fair_gnt[i]));
      if (fair_gnt[i] == 2'b10)
        check($sformatf("fair%0d.data", i), 32'(dout_b), 32'hB2);
    end
    req_b = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wrarb.md
# fifo_wrarb

Round-robin write-port arbiter that lets NREQ independent producers share the single write port of one `fifo` instance in the same clock domain. A requester holds a grant for a whole packet, up to BURST beats. Grants rotate fairly between requesters. The block sits directly in front of the fifo, drives its `write_i`/`data_i` and watches its `full_o`.

## Interface
- `NREQ`, default 2: number of requesters, ≥1.
- `WIDTH`, default 8: data width, matches the fifo `WIDTH`.
- `BURST`, default 4: maximum beats per grant, ≥1.
- `clk_i` input, 1 bit: single clock for all logic.
- `rst_i` input, 1 bit: reset, asynchronous and active-high.
- `req_i` input, NREQ bits: bit n is high while requester n has a beat to write.
- `last_i` input, NREQ bits: bit n marks requester n's current beat as end-of-packet.
- `data_i` input, NREQ*WIDTH bits: requester n's data sits in bits [n*WIDTH +: WIDTH].
- `gnt_o` output, NREQ bits: one-hot registered grant, or zero.
- `ack_o` output, NREQ bits: bit n high means requester n's beat is accepted this cycle.
- `write_o` output, 1 bit: connects to the fifo `write_i`.
- `data_o` output, WIDTH bits: connects to the fifo `data_i`.
- `full_i` input, 1 bit: connects to the fifo `full_o`.

## Operation
- State machine has two states: IDLE and BUSY.
- Registers:
  - `gidx`: granted index, clog2(NREQ) bits, minimum 1.
  - `ptr`: rotating-priority pointer, same width.
  - `cnt`: beat counter, clog2(BURST)+1 bits.
- Reset values: state IDLE, `gnt_o`=0, `gidx`=0, `ptr`=0, `cnt`=0. With `gnt_o`=0, the outputs `write_o`=0 and `ack_o`=0.
- IDLE with any `req_i` bit set:
  - Select the first set bit searching ptr, ptr+1, … NREQ-1, 0, … (modulo NREQ).
  - Load `gidx`, set `gnt_o` to the one-hot of `gidx`, clear `cnt`, go to BUSY.
- IDLE with `req_i`=0: stay in IDLE, `gnt_o`=0.
- BUSY combinational outputs:
  - `write_o` = `req_i[gidx]` & !`full_i`.
  - `ack_o` = `gnt_o` & {NREQ{`write_o`}}.
  - `data_o` = `data_i` slice `gidx`, whatever the value of `write_o`.
- BUSY, accepted beat (`write_o`=1): `cnt` increments.
- BUSY release conditions, any of:
  - accepted beat with `last_i[gidx]`=1;
  - accepted beat with `cnt` == BURST-1;
  - `req_i[gidx]`=0. The requester abandons the grant and no write happens that cycle.
- On release: go to IDLE, `gnt_o`=0, `ptr` = (`gidx`+1) mod NREQ (wraps when `gidx`=NREQ-1).
- BUSY with `full_i`=1: hold state. No write, no ack, `cnt` unchanged, grant kept.
- `last_i` of requesters that are not granted is ignored. `last_i[gidx]` is ignored on cycles with no write.
- NREQ=1: `ptr` stays 0 and the block degenerates to burst framing of a single source.
- Reset asserted mid-burst: immediate return to the reset values. A beat in that cycle is not written and not acked.

## Timing
- Request to grant: `req_i[n]` rises in IDLE at cycle t, `gnt_o[n]` is high at t+1.
- First write: at t+1 if `full_i`=0, giving 1-cycle arbitration latency.
- Beat rate: 1 beat per cycle while granted and not full.
- Release: triggered at cycle r, `gnt_o`=0 at r+1 (IDLE), next grant at r+2.
- Overhead is one idle cycle between grants, so maximum throughput per packet of k beats is k/(k+1).
- `write_o`, `ack_o` and `data_o` are combinational from `req_i`/`full_i`/`data_i` and registered state. `gnt_o` is a pure register.
- Requesters present stable `data_i`/`last_i` while `req_i` is high and no ack has occurred. A beat completes only on `ack_o`.

## Test plan
- Reset then single source: NREQ=2, BURST=4, req0 sends 3 beats 0x11,0x22,0x33 with last on 0x33.
  - Required: `gnt_o`=01 one cycle after req.
  - Required: `write_o` for 3 consecutive cycles with `data_o` 0x11,0x22,0x33.
  - Required: `gnt_o`=00 the next cycle.
- Fairness: req0 and req1 both held continuously with BURST=2 and no `last_i`.
  - Required grant sequence: 01,00,10,00,01,….
  - Required: each grant is exactly 2 acks.
  - Required: `ptr` wraps from 1 to 0.
- Backpressure: `full_i` high for 3 cycles in the middle of a burst.
  - Required: `write_o`=0 and `ack_o`=0 during those cycles; `cnt` and `gnt_o` held.
  - Required: the burst resumes with the next datum; no beat is lost or duplicated.
- Abandon: req1 drops mid-packet after 1 beat.
  - Required: no write that cycle; IDLE next cycle; next grant goes to req0 because `ptr` = 0.
- Reset mid-burst: `rst_i` pulses asynchronously during the 2nd beat.
  - Required: `gnt_o`, `write_o` and `ack_o` go to 0 immediately; after release, arbitration restarts from `ptr`=0.
- Scoreboard: with a real fifo of DEPTH=4 and a random reader, and NREQ=3 random packets, the readout matches each packet contiguously and in order.
